io_responder: RTL
=================

Name: io_responder

Overview:
- Peripheral-side endpoint of the CPU I/O bus.
- Consumes the chip selects (LEDCtrl / SwitchCtrl), address and write data produced by the CPU memory/IO bridge.
- Write side: holds a 24-bit LED output register, written one byte per access.
- Read side: synchronises and debounces 24 board switches and returns the addressed byte as 8-bit io_rdata for sign-extension into the register file.

Parameters:
- IO_BASE, 32'hFFFF_FC60, base address of the I/O window.
- LED_OFF, 4'h0, offset of LED byte 0; LED bytes sit at offsets 0..2.
- SW_OFF, 4'h0, offset of switch byte 0 within the switch window (IO_BASE+0x10); switch bytes sit at offsets 0..2.
- DEBOUNCE_CYCLES, 20'd200000, cycles a synchronised switch must stay stable before it is accepted.

Ports:
- clk  input  1  system clock, CPU clock domain
- rst_n  input  1  asynchronous active-low reset
- LEDCtrl  input  1  LED chip select (I/O write strobe), active high
- SwitchCtrl  input  1  switch chip select (I/O read strobe), active high
- addr_in  input  32  byte address from the bridge
- io_wdata  input  32  write data from the bridge; only [7:0] is used
- io_rdata  output  8  read data returned to the bridge
- sw_in  input  24  raw board switches, asynchronous
- led_out  output  24  LED drive, active high
- addr_err  output  1  one-cycle pulse when a strobe hits an unmapped address

Behaviour:
- Decode:
  - hit_led = addr_in[31:4] == IO_BASE[31:4] and addr_in[3:0] - LED_OFF < 3.
  - hit_sw = addr_in[31:4] == (IO_BASE+32'h10)[31:4] and addr_in[3:0] - SW_OFF < 3.
  - Byte index k = addr_in[1:0] relative to the offset.
- LED write:
  - On a rising clk edge with LEDCtrl=1 and hit_led, led_out[8k+7:8k] <= io_wdata[7:0]; other bytes are held.
  - Visible the cycle after the edge; one write per cycle.
- LEDCtrl=1 while SwitchCtrl=1 is legal:
  - The write is performed.
  - io_rdata reflects the switch mux, since reads have no side effects.
- Switch path, per bit:
  - 2-flop synchroniser feeds the debouncer.
  - Debouncer: the stable bit sw_db[i] and a shared-width counter cnt[i]. If sync[i] != sw_db[i], cnt increments; else cnt clears.
  - When cnt reaches DEBOUNCE_CYCLES-1, sw_db[i] <= sync[i] and cnt clears.
  - Latency of a clean edge: 2 + DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES never changes sw_db.
- Read:
  - io_rdata is combinational: if SwitchCtrl and hit_sw, io_rdata = sw_db[8k+7:8k]; else 8'h00.
  - It is stable for the whole CPU cycle because sw_db is registered.
- addr_err:
  - Registered; set for exactly one cycle after any edge where (LEDCtrl and not hit_led) or (SwitchCtrl and not hit_sw).
  - Unmapped writes do not alter led_out.
- Reset (rst_n low, asynchronous):
  - led_out=0, sw_db=0, synchronisers=0, all cnt=0, addr_err=0.
  - Reset asserted mid-debounce discards the pending count. After release, switches already high are accepted after 2+DEBOUNCE_CYCLES cycles.
- Widths: counters are ceil(log2(DEBOUNCE_CYCLES)) bits and never wrap past DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: IO_DEBOUNCE_EN.
- Defined: debouncer as above.
- Undefined: sw_db = synchroniser output directly and no counters are instantiated. Read latency is 2 cycles and glitches pass through. Simulation builds leave it undefined for speed.

Test Plan:
- Reset: hold rst_n=0 with sw_in=24'hFFFFFF -> led_out=0 and io_rdata=0 during reset. With IO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, io_rdata=8'hFF on byte 0 no earlier than 6 cycles after release.
- LED byte writes: LEDCtrl=1 with addr FFFFFC60/61/62 and io_wdata 0x12/0x34/0x56 on consecutive cycles -> led_out=24'h563412; a following write of 0xAA to FC61 -> 24'h56AA12.
- Switch read: sw_in=24'hC3A55A stable, SwitchCtrl=1, addr FFFFFC70/71/72 -> io_rdata 5A/A5/C3; SwitchCtrl=0 -> 00.
- Debounce (DEBOUNCE_CYCLES=4): 3-cycle pulse on sw_in[0] -> io_rdata stays 00; 5-cycle pulse -> bit 0 reads 1.
- Unmapped access: LEDCtrl=1 at FFFFFC63 or FFFFFC50 -> led_out unchanged, addr_err high for exactly one cycle.
- Async reset mid-operation: rst_n low for half a cycle after led_out=24'h563412 -> led_out=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/io_responder.sv
// io_responder - peripheral-side endpoint of the CPU I/O bus.
//
// Holds a 24-bit LED register written one byte per access and returns one
// byte of the synchronised (optionally debounced) board switches per read.
//
// Ports:
//   clk         system clock, CPU clock domain
//   rst_n       asynchronous active-low reset
//   LEDCtrl     LED chip select (I/O write strobe), active high
//   SwitchCtrl  switch chip select (I/O read strobe), active high
//   addr_in     byte address from the bridge
//   io_wdata    write data from the bridge, only [7:0] used
//   io_rdata    combinational read data (addressed switch byte or 0)
//   sw_in       raw asynchronous board switches
//   led_out     LED drive, active high
//   addr_err    one-cycle pulse after a strobe hits an unmapped address
//
// Build option: define IO_DEBOUNCE_EN to insert a per-bit debouncer after
// the synchroniser; without it the synchroniser output is read directly.
module io_responder #(
   parameter logic [31:0] IO_BASE         = 32'hFFFF_FC60,
   parameter logic [3:0]  LED_OFF         = 4'h0,
   parameter logic [3:0]  SW_OFF          = 4'h0,
   parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        LEDCtrl,
   input  logic        SwitchCtrl,
   input  logic [31:0] addr_in,
   input  logic [31:0] io_wdata,
   output logic [7:0]  io_rdata,
   input  logic [23:0] sw_in,
   output logic [23:0] led_out,
   output logic        addr_err
);

   localparam logic [31:0] SW_BASE = IO_BASE + 32'h10;

   logic [3:0]  led_rel;
   logic [3:0]  sw_rel;
   logic        hit_led;
   logic        hit_sw;
   logic [23:0] sync1;
   logic [23:0] sync2;
   logic [23:0] sw_db;
   logic        unused_bits;

   assign unused_bits = ^{io_wdata[31:8], DEBOUNCE_CYCLES};

   // Offsets are subtracted in 4 bits so an address below the offset wraps
   // to a large value and fails the range test.
   assign led_rel = addr_in[3:0] - LED_OFF;
   assign sw_rel  = addr_in[3:0] - SW_OFF;
   assign hit_led = (addr_in[31:4] == IO_BASE[31:4]) && (led_rel < 4'd3);
   assign hit_sw  = (addr_in[31:4] == SW_BASE[31:4]) && (sw_rel < 4'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_out <= '0;
      end else if (LEDCtrl && hit_led) begin
         case (led_rel[1:0])
            2'd0:    led_out[7:0]   <= io_wdata[7:0];
            2'd1:    led_out[15:8]  <= io_wdata[7:0];
            2'd2:    led_out[23:16] <= io_wdata[7:0];
            default: led_out        <= led_out;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_err <= 1'b0;
      end else begin
         addr_err <= (LEDCtrl && !hit_led) || (SwitchCtrl && !hit_sw);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_in;
         sync2 <= sync1;
      end
   end

`ifdef IO_DEBOUNCE_EN
   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt [24];

   // Each bit counts consecutive cycles of disagreement with its accepted
   // value; any agreement restarts the count, so short glitches never land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_db <= '0;
         for (int unsigned i = 0; i < 24; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 24; i++) begin
            if (sync2[i] != sw_db[i]) begin
               if (cnt[i] == CNT_MAX) begin
                  sw_db[i] <= sync2[i];
                  cnt[i]   <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end
`else
   always_comb begin
      sw_db = sync2;
   end
`endif

   always_comb begin
      io_rdata = '0;
      if (SwitchCtrl && hit_sw) begin
         case (sw_rel[1:0])
            2'd0:    io_rdata = sw_db[7:0];
            2'd1:    io_rdata = sw_db[15:8];
            2'd2:    io_rdata = sw_db[23:16];
            default: io_rdata = '0;
         endcase
      end
   end

endmodule
